// File: rtl/can_frame_replayer.sv
// FIFO-buffered CAN frame source: issues one frame at a time, waits for the extractor ack (or times out), then idles MIN_GAP cycles.
// Optional timestamp pacing of issues is compiled in when CAN_REPLAY_PACE_EN is defined.
module can_frame_replayer #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MIN_GAP        = 1,
  parameter int PACE_SHIFT     = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [63:0]              wr_timestamp,
  input  logic [28:0]              wr_arb_id,
  input  logic [63:0]              wr_data,
  output logic [63:0]              timestamp,
  output logic [28:0]              arbitration_id,
  output logic [63:0]              data_field,
  output logic                     frame_valid,
  input  logic                     fe_busy,
  input  logic                     fe_features_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [31:0]              frames_sent,
  output logic                     timeout_err,
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int GW = $clog2(MIN_GAP) + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    GAP      = 2'd3
  } state_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1 || MIN_GAP < 1 ||
      PACE_SHIFT < 0 || PACE_SHIFT > 63) begin : g_bad_params
    $error("can_frame_replayer: invalid parameter set");
  end

  logic [63:0]   mem_ts   [DEPTH];
  logic [28:0]   mem_id   [DEPTH];
  logic [63:0]   mem_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          pace_ok;
  logic [63:0]   head_ts;
  state_t        state_q;
  logic [TW-1:0] tmo_cnt;
  logic [GW-1:0] gap_cnt;

  // Full blocks writes even when a pop lands on the same edge.
  assign wr_ready   = (count != CW'(DEPTH));
  assign push       = wr_valid && wr_ready;
  assign head_ts    = mem_ts[rd_ptr];
  assign pop        = (state_q == IDLE) && (count != '0) && !fe_busy && pace_ok;
  assign fifo_count = count;
  assign state      = state_q;

  // NOTE: storage arrays carry no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_ts[wr_ptr]   <= wr_timestamp;
      mem_id[wr_ptr]   <= wr_arb_id;
      mem_data[wr_ptr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CAN_REPLAY_PACE_EN
  logic [31:0] pace_cnt;
  logic [31:0] pace_need;
  logic [63:0] last_ts;
  logic [63:0] ts_delta;
  logic [63:0] delta_shr;
  logic        paced;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    ts_delta  = (head_ts >= last_ts) ? (head_ts - last_ts) : '0;
    delta_shr = ts_delta >> PACE_SHIFT;
    pace_need = (|delta_shr[63:32]) ? '1 : delta_shr[31:0];
    pace_ok   = !paced || (pace_cnt >= pace_need);
  end

  // The first frame after reset issues unpaced; the counter saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pace_cnt <= '0;
      last_ts  <= '0;
      paced    <= 1'b0;
    end else if (pop) begin
      pace_cnt <= '0;
      last_ts  <= head_ts;
      paced    <= 1'b1;
    end else if (pace_cnt != '1) begin
      pace_cnt <= pace_cnt + 1'b1;
    end
  end
`else
  assign pace_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      frame_valid    <= 1'b0;
      timestamp      <= '0;
      arbitration_id <= '0;
      data_field     <= '0;
      frames_sent    <= '0;
      timeout_err    <= 1'b0;
      tmo_cnt        <= '0;
      gap_cnt        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            timestamp      <= head_ts;
            arbitration_id <= mem_id[rd_ptr];
            data_field     <= mem_data[rd_ptr];
            frame_valid    <= 1'b1;
            state_q        <= ISSUE;
          end
        end
        ISSUE: begin
          frame_valid <= 1'b0;
          tmo_cnt     <= '0;
          state_q     <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // An ack on the final allowed cycle still counts as delivered.
          if (fe_features_ready) begin
            frames_sent <= frames_sent + 32'd1;
            gap_cnt     <= '0;
            state_q     <= GAP;
          end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            gap_cnt     <= '0;
            state_q     <= GAP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(MIN_GAP - 1)) state_q <= IDLE;
          else                             gap_cnt <= gap_cnt + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_can_frame_replayer.sv
// Directed bench for can_frame_replayer: table-driven single-frame vectors plus hand sequences
// for reset, timeout, full FIFO, busy stall and (when compiled in) timestamp pacing.
module tb_can_frame_replayer;

  localparam int DEPTH = 8;
  localparam int TMO   = 64;
  localparam int GAP_N = 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   wr_valid = 1'b0;
  logic                   wr_ready;
  logic [63:0]            wr_timestamp = '0;
  logic [28:0]            wr_arb_id = '0;
  logic [63:0]            wr_data = '0;
  logic [63:0]            timestamp;
  logic [28:0]            arbitration_id;
  logic [63:0]            data_field;
  logic                   frame_valid;
  logic                   fe_busy = 1'b0;
  logic                   fe_features_ready;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [31:0]            frames_sent;
  logic                   timeout_err;
  logic [1:0]             state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ack_delay = 4;
  bit ack_en    = 1'b1;
  int fv_seen    = 0;
  int proto_viol = 0;
  bit outstanding = 1'b0;
  bit fv_prev     = 1'b0;
  logic [28:0] issued_ids[$];
  int          fv_times[$];

  can_frame_replayer #(
    .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .MIN_GAP(GAP_N), .PACE_SHIFT(20)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_timestamp(wr_timestamp), .wr_arb_id(wr_arb_id), .wr_data(wr_data),
    .timestamp(timestamp), .arbitration_id(arbitration_id), .data_field(data_field),
    .frame_valid(frame_valid), .fe_busy(fe_busy), .fe_features_ready(fe_features_ready),
    .fifo_count(fifo_count), .frames_sent(frames_sent), .timeout_err(timeout_err),
    .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Extractor model: one-cycle ack pulse ack_delay cycles after seeing frame_valid.
  initial begin
    fe_features_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && frame_valid && ack_en) begin
        repeat (ack_delay) @(posedge clk);
        #1 fe_features_ready = 1'b1;
        @(posedge clk);
        #1 fe_features_ready = 1'b0;
      end
    end
  end

  // Issue monitor: records order/timing and flags double-wide pulses or issues without a prior completion.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding = 1'b0;
      fv_prev     = 1'b0;
    end else begin
      if (frame_valid) begin
        if (fv_prev || outstanding) proto_viol++;
        outstanding = 1'b1;
        fv_seen++;
        issued_ids.push_back(arbitration_id);
        fv_times.push_back(cyc);
      end
      if (state == 2'd3) outstanding = 1'b0;
      fv_prev = frame_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    fe_busy  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic push(input logic [63:0] ts, input logic [28:0] id, input logic [63:0] data);
    int n = 0;
    wr_valid     = 1'b1;
    wr_timestamp = ts;
    wr_arb_id    = id;
    wr_data      = data;
    while (!wr_ready && n < 1000) begin
      tick();
      n++;
    end
    if (!wr_ready) check("push_ready", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
  endtask

  // Counts negedges until state matches; ends on a negedge.
  task automatic wait_state(input logic [1:0] s, input int budget, output int n);
    n = 0;
    @(negedge clk);
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (state !== s) check("wait_state", state, s);
  endtask

  typedef struct {
    logic [63:0] ts;
    logic [28:0] id;
    logic [63:0] data;
    int          ack;
    int          exp_sent;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    int base;
    logic [7:0] b;

    vecs[0] = '{64'd1000, 29'h0C9, 64'h8416690D00000000, 4, 1};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 29'h1FFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2};
    vecs[2] = '{64'd0, 29'h0, 64'h0, 2, 3};
    vecs[3] = '{64'h0123_4567_89AB_CDEF, 29'h1555_5555, 64'hA5A5_5A5A_0F0F_F0F0, TMO - 1, 4};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_frame_valid", frame_valid, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_state", state, 0);
    check("rst_frames_sent", frames_sent, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    tick();

    // Single-frame vectors into an empty FIFO; latest vector acks on the last cycle before timeout.
    for (int i = 0; i < 4; i++) begin
      ack_delay = vecs[i].ack;
      push(vecs[i].ts, vecs[i].id, vecs[i].data);
      check($sformatf("v%0d_count_after_write", i), fifo_count, 1);
      @(negedge clk);
      check($sformatf("v%0d_fv_before_issue", i), frame_valid, 0);
      @(negedge clk);
      check($sformatf("v%0d_fv", i), frame_valid, 1);
      check($sformatf("v%0d_ts", i), timestamp, vecs[i].ts);
      check($sformatf("v%0d_id", i), arbitration_id, vecs[i].id);
      check($sformatf("v%0d_data", i), data_field, vecs[i].data);
      check($sformatf("v%0d_state_issue", i), state, 1);
      check($sformatf("v%0d_count_popped", i), fifo_count, 0);
      n = 0;
      while (state !== 2'd0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("v%0d_done_latency", i), n, vecs[i].ack + 2);
      check($sformatf("v%0d_frames_sent", i), frames_sent, vecs[i].exp_sent);
      check($sformatf("v%0d_timeout_err", i), timeout_err, 0);
      check($sformatf("v%0d_hold_id", i), arbitration_id, vecs[i].id);
      tick();
    end
    check("vec_protocol", proto_viol, 0);

    // Async reset in WAIT_ACK with one more frame queued behind it
    ack_en = 1'b0;
    push(64'd77, 29'h77, 64'h7777);
    push(64'd78, 29'h78, 64'h7878);
    check("rst_seq_push_pop_count", fifo_count, 1);
    wait_state(2'd2, 20, n);
    #2 rst_n = 1'b0;
    #1;
    check("arst_frame_valid", frame_valid, 0);
    check("arst_timestamp", timestamp, 0);
    check("arst_id", arbitration_id, 0);
    check("arst_data", data_field, 0);
    check("arst_fifo_count", fifo_count, 0);
    check("arst_frames_sent", frames_sent, 0);
    check("arst_timeout_err", timeout_err, 0);
    check("arst_state", state, 0);
    check("arst_wr_ready", wr_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = fv_seen;
    repeat (5) tick();
    check("arst_dropped_count", fifo_count, 0);
    check("arst_no_issue", fv_seen, base);

    // Ack timeout, then the queued frame still issues
    ack_en    = 1'b0;
    ack_delay = 3;
    push(64'd5, 29'h0A1, 64'h1111);
    push(64'd6, 29'h0B2, 64'h2222);
    @(negedge clk);
    check("tmo_first_fv", frame_valid, 1);
    check("tmo_first_id", arbitration_id, 29'h0A1);
    n = 0;
    while (!timeout_err && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tmo_latency", n, TMO + 1);
    check("tmo_frames_sent", frames_sent, 0);
    check("tmo_state_gap", state, 3);
    ack_en = 1'b1;
    n = 0;
    while (!frame_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("tmo_next_latency", n, GAP_N + 1);
    check("tmo_next_id", arbitration_id, 29'h0B2);
    wait_state(2'd0, 200, n);
    check("tmo_next_sent", frames_sent, 1);
    check("tmo_sticky", timeout_err, 1);
    tick();

    // Full FIFO under busy, ninth write held, then in-order drain
    apply_reset();
    ack_delay = 2;
    issued_ids.delete();
    proto_viol = 0;
    fe_busy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      b = 8'(i);
      push(64'(i * 100), 29'(i), {8{b}});
    end
    check("full_count", fifo_count, 8);
    check("full_wr_ready", wr_ready, 0);
    base = fv_seen;
    wr_valid     = 1'b1;
    wr_timestamp = 64'd900;
    wr_arb_id    = 29'd9;
    wr_data      = {8{8'h09}};
    repeat (3) tick();
    check("full_held_count", fifo_count, 8);
    check("full_busy_no_issue", fv_seen, base);
    fe_busy = 1'b0;
    tick();
    check("full_pop_no_push", fifo_count, 7);
    check("full_ready_after_pop", wr_ready, 1);
    push(64'd900, 29'd9, {8{8'h09}});
    n = 0;
    while (frames_sent !== 32'd9 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("full_frames_sent", frames_sent, 9);
    check("full_issue_count", issued_ids.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < issued_ids.size()) check($sformatf("full_order_%0d", i), issued_ids[i], 29'(i + 1));
    end
    check("full_protocol", proto_viol, 0);
    tick();

    // Busy stall: no issue while busy, issue on the edge after busy falls
    apply_reset();
    fe_busy = 1'b1;
    base = fv_seen;
    push(64'd42, 29'h03C, 64'h3C3C);
    repeat (20) tick();
    check("busy_no_issue", fv_seen, base);
    check("busy_count", fifo_count, 1);
    check("busy_state", state, 0);
    fe_busy = 1'b0;
    @(negedge clk);
    check("busy_fv_before_edge", frame_valid, 0);
    @(negedge clk);
    check("busy_fv_after_edge", frame_valid, 1);
    check("busy_id", arbitration_id, 29'h03C);
    wait_state(2'd0, 200, n);
    check("busy_sent", frames_sent, 1);
    tick();

`ifdef CAN_REPLAY_PACE_EN
    // Pacing: 5<<20 timestamp step forces >=5 cycles; a backwards timestamp is unpaced.
    apply_reset();
    ack_delay = 1;
    fv_times.delete();
    push(64'd0, 29'd1, 64'h1);
    push(64'd5 << 20, 29'd2, 64'h2);
    push(64'd0, 29'd3, 64'h3);
    n = 0;
    while (frames_sent !== 32'd3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("pace_sent", frames_sent, 3);
    check("pace_issues", fv_times.size(), 3);
    if (fv_times.size() == 3) begin
      check("pace_gap_ge5", (fv_times[1] - fv_times[0]) >= 5, 1);
      check("pace_backwards_gap", fv_times[2] - fv_times[1], 4);
    end
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
